// File: rtl/i2s_tx_scheduler_if.sv
// rtl/i2s_tx_scheduler_if.sv - producer handshake and TX FIFO write bundle
// The master side is the scheduler: it takes source pairs and drives the FIFO writes.
interface i2s_tx_scheduler_if #(
  parameter int N_SRC = 4,
  parameter int DW    = 32
);
  logic [N_SRC-1:0]    i_src_valid;
  logic [N_SRC*DW-1:0] i_src_left;
  logic [N_SRC*DW-1:0] i_src_right;
  logic [N_SRC-1:0]    o_src_ready;
  logic                o_txl_wr;
  logic                o_txr_wr;
  logic [DW-1:0]       o_txl_data;
  logic [DW-1:0]       o_txr_data;
  logic                i_txl_full;
  logic                i_txr_full;

  modport master (
    input  i_src_valid, i_src_left, i_src_right, i_txl_full, i_txr_full,
    output o_src_ready, o_txl_wr, o_txr_wr, o_txl_data, o_txr_data
  );

  modport slave (
    output i_src_valid, i_src_left, i_src_right, i_txl_full, i_txr_full,
    input  o_src_ready, o_txl_wr, o_txr_wr, o_txl_data, o_txr_data
  );
endinterface

// File: rtl/i2s_tx_scheduler.sv
// rtl/i2s_tx_scheduler.sv - round-robin stereo pair scheduler into the I2S TX FIFOs
// Grants bursts of up to BURST pairs per source and counts FIFO underruns.
module i2s_tx_scheduler #(
  parameter int N_SRC = 4,
  parameter int DW    = 32,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic [N_SRC-1:0]           i_src_mask,
  i2s_tx_scheduler_if.master         bus,
  input  logic                       i_txl_empty,
  input  logic                       i_txr_empty,
  input  logic                       i_data_rqst,
  input  logic                       i_underrun_clr,
  output logic [$clog2(N_SRC)-1:0]   o_grant_id,
  output logic                       o_busy,
  output logic                       o_underrun,
  output logic [CNT_W-1:0]           o_underrun_cnt
);

  localparam int GW = $clog2(N_SRC);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, SELECT, PUSH} state_t;

  state_t         state_q;
  logic [GW-1:0]  grant_q;
  logic [GW-1:0]  last_q;
  logic [BW-1:0]  burst_q;
  logic           underrun_q, underrun_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DW-1:0]    left_w  [N_SRC];
  logic [DW-1:0]    right_w [N_SRC];
  logic [N_SRC-1:0] eligible;
  logic [GW-1:0]    cand;
  logic [GW-1:0]    sel_idx;
  logic             sel_hit;
  logic             g_valid;
  logic             fifo_ok;
  logic             xfer;
  logic             unr_evt;

  for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
    assign left_w[k]  = bus.i_src_left[k*DW +: DW];
    assign right_w[k] = bus.i_src_right[k*DW +: DW];
  end

  assign eligible = bus.i_src_valid & i_src_mask;
  assign g_valid  = eligible[grant_q];
  assign fifo_ok  = !bus.i_txl_full && !bus.i_txr_full;
  // Enable gates the strobes directly so a held pair is never half-accepted.
  assign xfer     = (state_q == PUSH) && i_enable && g_valid && fifo_ok;

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = GW'((int'(last_q) + i) % N_SRC);
      if (!sel_hit && eligible[cand]) begin
        sel_hit = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    bus.o_src_ready = '0;
    for (int k = 0; k < N_SRC; k++) begin
      bus.o_src_ready[k] = xfer && (grant_q == GW'(k));
    end
  end

  assign bus.o_txl_wr   = xfer;
  assign bus.o_txr_wr   = xfer;
  assign bus.o_txl_data = (state_q == PUSH) ? left_w[grant_q]  : '0;
  assign bus.o_txr_data = (state_q == PUSH) ? right_w[grant_q] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_SRC - 1);
      burst_q <= '0;
    end else if (!i_enable) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: state_q <= SELECT;
        SELECT: begin
          if (sel_hit) begin
            grant_q <= sel_idx;
            burst_q <= '0;
            state_q <= PUSH;
          end
        end
        PUSH: begin
          if (!g_valid) begin
            last_q  <= grant_q;
            state_q <= SELECT;
          end else if (fifo_ok) begin
            burst_q <= burst_q + BW'(1);
            if (int'(burst_q) + 1 >= BURST) begin
              last_q  <= grant_q;
              state_q <= SELECT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign unr_evt = i_enable && i_data_rqst && (i_txl_empty || i_txr_empty);

  always_comb begin
    underrun_d = underrun_q;
    cnt_d      = cnt_q;
    if (i_underrun_clr) begin
      underrun_d = 1'b0;
      cnt_d      = '0;
    end else if (unr_evt) begin
      underrun_d = 1'b1;
      if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_grant_id     = grant_q;
  assign o_busy         = (state_q == PUSH);
  assign o_underrun     = underrun_q;
  assign o_underrun_cnt = cnt_q;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// tb/tb_i2s_tx_scheduler.sv - scoreboard bench for i2s_tx_scheduler
// Directed stimulus queues expected FIFO writes; a negedge monitor pops and compares.
module tb_i2s_tx_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [3:0]  mask;
  logic        txl_empty, txr_empty, rqst, clr;
  logic [1:0]  grant_id;
  logic        busy, underrun;
  logic [15:0] ucnt;

  logic        en2, rqst2, clr2, empty2;
  logic [3:0]  mask2;
  logic [1:0]  grant2;
  logic        busy2, underrun2;
  logic [1:0]  ucnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          src;
    logic [31:0] l;
    logic [31:0] r;
  } exp_t;
  exp_t q[$];

  int         pcnt[N];
  logic [3:0] fire_q;

  i2s_tx_scheduler_if #(.N_SRC(N), .DW(DW)) bus ();
  i2s_tx_scheduler_if #(.N_SRC(N), .DW(DW)) bus2 ();

  i2s_tx_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_src_mask(mask), .bus(bus),
    .i_txl_empty(txl_empty), .i_txr_empty(txr_empty), .i_data_rqst(rqst),
    .i_underrun_clr(clr), .o_grant_id(grant_id), .o_busy(busy),
    .o_underrun(underrun), .o_underrun_cnt(ucnt)
  );

  i2s_tx_scheduler #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_enable(en2), .i_src_mask(mask2), .bus(bus2),
    .i_txl_empty(empty2), .i_txr_empty(empty2), .i_data_rqst(rqst2),
    .i_underrun_clr(clr2), .o_grant_id(grant2), .o_busy(busy2),
    .o_underrun(underrun2), .o_underrun_cnt(ucnt2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_l(int k, int n);
    return 32'h1111_0000 + 32'(k << 12) + 32'(n);
  endfunction

  function automatic logic [31:0] mk_r(int k, int n);
    return 32'h2222_0000 + 32'(k << 12) + 32'(n);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < N; k++) begin
      bus.i_src_left[k*DW +: DW]  = mk_l(k, pcnt[k]);
      bus.i_src_right[k*DW +: DW] = mk_r(k, pcnt[k]);
    end
  endtask

  // Advance past the next rising edge; consume handshakes seen in the previous cycle.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (fire_q[k]) pcnt[k]++;
    fire_q = '0;
    drive_src();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_pairs(input int k, input int n0, input int cnt);
    exp_t e;
    for (int n = n0; n < n0 + cnt; n++) begin
      e.src = k;
      e.l   = mk_l(k, n);
      e.r   = mk_r(k, n);
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; mask = '0; clr = 1'b0; rqst = 1'b0;
    txl_empty = 1'b0; txr_empty = 1'b0;
    bus.i_src_valid = '0; bus.i_txl_full = 1'b0; bus.i_txr_full = 1'b0;
    for (int k = 0; k < N; k++) pcnt[k] = 0;
    fire_q = '0;
    drive_src();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    enable = 1'b0;
    steps(2);
    chk(name, 64'(q.size()), 64'd0);
    q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    fire_q = bus.i_src_valid & bus.o_src_ready;
    if (bus.o_txl_wr || bus.o_txr_wr) begin
      chk("wr_pair", {bus.o_txl_wr, bus.o_txr_wr}, 2'b11);
      chk("wr_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_grant", grant_id, 64'(e.src));
        chk("wr_ready", bus.o_src_ready, 64'(4'b0001 << e.src));
        chk("wr_left", bus.o_txl_data, e.l);
        chk("wr_right", bus.o_txr_data, e.r);
      end
    end
  end

  initial begin
    en2 = 1'b1; rqst2 = 1'b0; clr2 = 1'b0; empty2 = 1'b1; mask2 = '0;
    bus2.i_src_valid = '0; bus2.i_src_left = '0; bus2.i_src_right = '0;
    bus2.i_txl_full = 1'b0; bus2.i_txr_full = 1'b0;
    bus.i_src_left = '0; bus.i_src_right = '0;

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_wr", {bus.o_txl_wr, bus.o_txr_wr}, 0);
    chk("rst_ready", bus.o_src_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_data", {bus.o_txl_data, bus.o_txr_data}, 0);
    chk("rst_underrun", {underrun, ucnt}, 0);

    // single source: 2-cycle latency, burst of 4, one SELECT gap, re-grant
    mask = 4'b0001; bus.i_src_valid = 4'b0001; expect_pairs(0, 0, 8); enable = 1'b1;
    step(); chk("t1_c1_wr", bus.o_txl_wr, 0); chk("t1_c1_busy", busy, 0);
    step(); chk("t1_c2_wr", bus.o_txl_wr, 1); chk("t1_c2_busy", busy, 1);
    steps(3);
    step(); chk("t1_gap_wr", bus.o_txl_wr, 0); chk("t1_gap_busy", busy, 0);
    step(); chk("t1_regrant_wr", bus.o_txl_wr, 1);
    steps(4);
    drain("t1_drain");

    // all sources, full mask: 0,1,2,3,0
    do_reset();
    mask = 4'b1111; bus.i_src_valid = 4'b1111;
    expect_pairs(0, 0, 4); expect_pairs(1, 0, 4); expect_pairs(2, 0, 4);
    expect_pairs(3, 0, 4); expect_pairs(0, 4, 4);
    enable = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step();
      if (c == 7)  chk("t2_grant1", grant_id, 1);
      if (c == 17) chk("t2_grant3", grant_id, 3);
    end
    drain("t2_drain");

    // mask 1010: alternate 1,3
    do_reset();
    mask = 4'b1010; bus.i_src_valid = 4'b1111;
    expect_pairs(1, 0, 4); expect_pairs(3, 0, 4); expect_pairs(1, 4, 4);
    enable = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 7) chk("t2m_grant3", grant_id, 3);
    end
    drain("t2m_drain");

    // right FIFO full for 3 cycles stalls the burst without splitting writes
    do_reset();
    mask = 4'b0001; bus.i_src_valid = 4'b0001; expect_pairs(0, 0, 4); enable = 1'b1;
    steps(2);
    step(); bus.i_txr_full = 1'b1; #1;
    chk("t3_full1_wr", {bus.o_txl_wr, bus.o_txr_wr}, 0); chk("t3_full1_rdy", bus.o_src_ready, 0);
    step(); chk("t3_full2_wr", {bus.o_txl_wr, bus.o_txr_wr}, 0);
    step(); chk("t3_full3_wr", {bus.o_txl_wr, bus.o_txr_wr}, 0); chk("t3_full3_busy", busy, 1);
    step(); bus.i_txr_full = 1'b0; #1;
    chk("t3_resume_wr", bus.o_txl_wr, 1); chk("t3_resume_l", bus.o_txl_data, 32'h1111_0001);
    steps(3);
    drain("t3_drain");

    // source 2 drops valid mid-burst; next grant goes to 3
    do_reset();
    mask = 4'b1100; bus.i_src_valid = 4'b1100;
    expect_pairs(2, 0, 2); expect_pairs(3, 0, 4); enable = 1'b1;
    steps(3);
    step(); bus.i_src_valid = 4'b1000; #1; chk("t4_drop_wr", bus.o_txl_wr, 0);
    step(); chk("t4_sel_busy", busy, 0);
    step(); chk("t4_grant3", grant_id, 3); chk("t4_grant3_wr", bus.o_txl_wr, 1);
    steps(4);
    drain("t4_drain");

    // enable drops in a transfer cycle; held pair written once after re-enable
    do_reset();
    mask = 4'b0001; bus.i_src_valid = 4'b0001;
    expect_pairs(0, 0, 1); expect_pairs(0, 1, 4); enable = 1'b1;
    steps(2);
    step(); enable = 1'b0; #1;
    chk("t5_dis_wr", {bus.o_txl_wr, bus.o_txr_wr}, 0); chk("t5_dis_rdy", bus.o_src_ready, 0);
    step(); chk("t5_idle_busy", busy, 0); enable = 1'b1;
    step(); chk("t5_sel_busy", busy, 0);
    step(); chk("t5_rewr", bus.o_txl_wr, 1); chk("t5_rewr_l", bus.o_txl_data, 32'h1111_0001);
    steps(4);
    drain("t5_drain");

    // underrun flag and counter
    do_reset();
    enable = 1'b1; txl_empty = 1'b1; txr_empty = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      rqst = 1'b1; step(); rqst = 1'b0;
      chk("t6_cnt", ucnt, 64'(i));
      step();
    end
    chk("t6_flag", underrun, 1);
    txl_empty = 1'b0;
    rqst = 1'b1; step(); rqst = 1'b0;
    chk("t6_noempty_cnt", ucnt, 3);
    txr_empty = 1'b1;
    rqst = 1'b1; clr = 1'b1; step(); rqst = 1'b0; clr = 1'b0;
    chk("t6_clr", {underrun, ucnt}, 0);
    enable = 1'b0;
    rqst = 1'b1; step(); rqst = 1'b0;
    chk("t6_dis_cnt", {underrun, ucnt}, 0);
    for (int i = 1; i <= 5; i++) begin
      rqst2 = 1'b1; step(); rqst2 = 1'b0;
      chk("t6_sat_cnt", ucnt2, 64'((i > 3) ? 3 : i));
    end
    chk("t6_sat_flag", underrun2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
